// File: rtl/h14tx_period_sched.sv
// HDMI 1.4 TX period sequencer: delays raw timing so that preambles and guard
// bands can precede active characters, and drives the per-channel control words.
package h14tx_period_sched_pkg;
  typedef logic [1:0] ctl_t;

  typedef enum logic [2:0] {
    P_CTL         = 3'd0,
    P_VID_PRE     = 3'd1,
    P_VID_GB      = 3'd2,
    P_VID         = 3'd3,
    P_DI_PRE      = 3'd4,
    P_DI_GB_LEAD  = 3'd5,
    P_DI          = 3'd6,
    P_DI_GB_TRAIL = 3'd7
  } period_t;
endpackage

module h14tx_period_sched
  import h14tx_period_sched_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int PKT_LEN      = 32,
  parameter int MAX_PKT      = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       island_go,
  input  logic [4:0] island_npkt,
  output logic [2:0] period,
  output ctl_t       ctl0,
  output ctl_t       ctl1,
  output ctl_t       ctl2,
  output logic       de_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       island_ready,
  output logic       island_pkt_start,
  output logic       overrun
);
  localparam int L       = PREAMBLE_LEN + GUARD_LEN + 1;
  localparam int GAP_MIN = L + 1;
  localparam int LW      = $clog2(GAP_MIN + 1);
  localparam int CMAX    = (PKT_LEN > PREAMBLE_LEN)
                           ? ((PKT_LEN > GUARD_LEN) ? PKT_LEN : GUARD_LEN)
                           : ((PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN);
  localparam int CW      = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int PW      = $clog2(MAX_PKT + 1);
  localparam logic [3:0] RUN_MAX   = 4'd15;
  localparam logic [3:0] RUN_READY = 4'd4;

  period_t        state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [PW-1:0]  pcnt, pcnt_n;
  logic [PW-1:0]  npkt_r, npkt_n, npkt_clamp;
  logic [L-1:0]   de_p, hs_p, vs_p;
  logic [L-1:0]   de_pn, hs_pn, vs_pn;
  logic [LW-1:0]  low_run, low_run_n;
  logic [3:0]     ctl_run, ctl_run_n;
  logic           rise, in_island, collide, accept, vid_start;
  logic           ready_n, pkt_start_n;
  ctl_t           ctl1_n, ctl2_n;

  always_comb begin
    de_pn = {de_p[L-2:0], de};
    hs_pn = {hs_p[L-2:0], hsync};
    vs_pn = {vs_p[L-2:0], vsync};

    rise      = de & ~de_p[0];
    in_island = state inside {P_DI_PRE, P_DI_GB_LEAD, P_DI, P_DI_GB_TRAIL};
    collide   = rise & in_island;
    // A colliding island is abandoned in favour of the normal video schedule.
    vid_start = rise & ((low_run >= LW'(GAP_MIN)) | in_island);
    accept    = island_go & island_ready & ~de;

    low_run_n = de ? '0 : ((low_run == LW'(GAP_MIN)) ? low_run : low_run + 1'b1);

    if (island_npkt == '0)
      npkt_clamp = PW'(1);
    else if (int'(island_npkt) > MAX_PKT)
      npkt_clamp = PW'(MAX_PKT);
    else
      npkt_clamp = PW'(island_npkt);

    state_n = state;
    cnt_n   = cnt;
    pcnt_n  = pcnt;
    npkt_n  = npkt_r;

    if (vid_start) begin
      state_n = P_VID_PRE;
      cnt_n   = '0;
      pcnt_n  = '0;
    end else begin
      case (state)
        P_CTL: begin
          // Short blanking gaps go straight back to VID without preamble.
          if (de_p[L-2]) begin
            state_n = P_VID;
          end else if (accept) begin
            state_n = P_DI_PRE;
            cnt_n   = '0;
            pcnt_n  = '0;
            npkt_n  = npkt_clamp;
          end
        end
        P_VID_PRE: begin
          if (cnt == CW'(PREAMBLE_LEN - 1)) begin
            state_n = P_VID_GB;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        P_VID_GB: begin
          if (cnt == CW'(GUARD_LEN - 1)) begin
            state_n = de_p[L-2] ? P_VID : P_CTL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        P_VID: state_n = de_p[L-2] ? P_VID : P_CTL;
        P_DI_PRE: begin
          if (cnt == CW'(PREAMBLE_LEN - 1)) begin
            state_n = P_DI_GB_LEAD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        P_DI_GB_LEAD: begin
          if (cnt == CW'(GUARD_LEN - 1)) begin
            state_n = P_DI;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        P_DI: begin
          if (cnt == CW'(PKT_LEN - 1)) begin
            cnt_n = '0;
            if (pcnt == npkt_r - 1'b1)
              state_n = P_DI_GB_TRAIL;
            else
              pcnt_n = pcnt + 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        P_DI_GB_TRAIL: begin
          if (cnt == CW'(GUARD_LEN - 1)) begin
            state_n = P_CTL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = P_CTL;
      endcase
    end

    // Run length of CTL output cycles strictly before the next cycle.
    if (state == P_CTL)
      ctl_run_n = (ctl_run == RUN_MAX) ? ctl_run : ctl_run + 1'b1;
    else
      ctl_run_n = '0;

    ready_n     = (state_n == P_CTL) && (ctl_run_n >= RUN_READY) && (de_pn == '0);
    pkt_start_n = (state_n == P_DI) && (cnt_n == '0);

    ctl1_n = ((state_n == P_VID_PRE) || (state_n == P_DI_PRE)) ? 2'b01 : 2'b00;
    ctl2_n = (state_n == P_DI_PRE) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= P_CTL;
      cnt              <= '0;
      pcnt             <= '0;
      npkt_r           <= '0;
      de_p             <= '0;
      hs_p             <= '0;
      vs_p             <= '0;
      low_run          <= '0;
      ctl_run          <= '0;
      ctl0             <= '0;
      ctl1             <= '0;
      ctl2             <= '0;
      island_ready     <= 1'b0;
      island_pkt_start <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      pcnt             <= pcnt_n;
      npkt_r           <= npkt_n;
      de_p             <= de_pn;
      hs_p             <= hs_pn;
      vs_p             <= vs_pn;
      low_run          <= low_run_n;
      ctl_run          <= ctl_run_n;
      ctl0             <= {vs_pn[L-1], hs_pn[L-1]};
      ctl1             <= ctl1_n;
      ctl2             <= ctl2_n;
      island_ready     <= ready_n;
      island_pkt_start <= pkt_start_n;
      overrun          <= overrun | collide;
    end
  end

  assign period  = state;
  assign de_o    = de_p[L-1];
  assign hsync_o = hs_p[L-1];
  assign vsync_o = vs_p[L-1];

endmodule
